// File: rtl/xgriscv_fetch_queue_pkg.sv
// Shared constants for the fetch queue: default depth, PC increment and queue entry width.
package xgriscv_fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int PC_STEP  = 4;

    // A queue entry is {pc, instr}.
    function automatic int fqEntryW(input int addrW, input int instrW);
        return addrW + instrW;
    endfunction

endpackage

// File: rtl/xgriscv_fetch_queue_if.sv
// Fetch-queue boundary: redirect from EX, IMEM request/response, and the valid/ready link to ID.
interface xgriscv_fetch_queue_if
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = $clog2(FQ_DEPTH + 1)
);
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;
    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_rvalid_i;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [INSTR_W-1:0] out_instr_o;
    logic [ADDR_W-1:0]  out_pc_o;
    logic [ADDR_W-1:0]  out_pcplus4_o;
    logic [CNT_W-1:0]   count_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, out_ready_i,
        output imem_req_o, imem_addr_o, out_valid_o, out_instr_o, out_pc_o,
               out_pcplus4_o, count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, out_ready_i,
        input  imem_req_o, imem_addr_o, out_valid_o, out_instr_o, out_pc_o,
               out_pcplus4_o, count_o
    );
endinterface

// File: rtl/xgriscv_fq_buf.sv
// Circular entry store with wrap-at-DEPTH pointers (any DEPTH >= 2), occupancy count and clear.
// Head entry is read combinationally; push/pop are ignored in a clear cycle.
module xgriscv_fq_buf
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = fqEntryW(32, 32),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wrPtr] <= pushData;
    end

    assign popData = mem[rdPtr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/xgriscv_fetch_queue.sv
// IF stage: owns the fetch PC, issues credit-limited 1-cycle IMEM reads and queues {pc, instr} for ID.
// Define XGRISCV_FQ_BYPASS_EN to hand a response straight to ID when the queue is empty.
module xgriscv_fetch_queue
    import xgriscv_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = FQ_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                   clk,
    input logic                   reset,
    xgriscv_fetch_queue_if.master fq
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = fqEntryW(ADDR_W, INSTR_W);

    logic [ADDR_W-1:0]  fetchPc;
    logic [ADDR_W-1:0]  reqPc;
    logic               inflight;
    logic               issue;
    logic [OCC_W-1:0]   occupancy;
    logic               respAccept;
    logic               bypassSel;
    logic               push;
    logic               pop;
    logic               bufFull;
    logic               bufEmpty;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] headEntry;
    logic               selVld;
    logic [ADDR_W-1:0]  selPc;
    logic [INSTR_W-1:0] selInstr;

    // Queued entries plus the outstanding read must fit, so a response always has a slot.
    assign occupancy  = {1'b0, count} + OCC_W'(inflight);
    assign issue      = !reset && !fq.redirect_i && (occupancy < OCC_W'(DEPTH));
    assign respAccept = !reset && !fq.redirect_i && fq.imem_rvalid_i;

`ifdef XGRISCV_FQ_BYPASS_EN
    assign bypassSel = !reset && bufEmpty && fq.imem_rvalid_i;
    assign push      = respAccept && !(bypassSel && fq.out_ready_i);
`else
    assign bypassSel = 1'b0;
    assign push      = respAccept;
`endif

    assign pop = fq.out_valid_o && fq.out_ready_i && !bufEmpty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc  <= RESET_PC;
            reqPc    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (fq.redirect_i) begin
                fetchPc <= fq.redirect_pc_i & ~ADDR_W'(3);
            end else if (issue) begin
                fetchPc <= fetchPc + ADDR_W'(PC_STEP);
                reqPc   <= fetchPc;
            end
        end
    end

    xgriscv_fq_buf #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (fq.redirect_i),
        .push     (push),
        .pushData ({reqPc, fq.imem_rdata_i}),
        .pop      (pop),
        .popData  (headEntry),
        .count    (count),
        .full     (bufFull),
        .empty    (bufEmpty)
    );

    always_comb begin
        selVld   = 1'b0;
        selPc    = '0;
        selInstr = '0;
        if (bypassSel) begin
            selVld   = 1'b1;
            selPc    = reqPc;
            selInstr = fq.imem_rdata_i;
        end else if (!bufEmpty) begin
            selVld            = 1'b1;
            {selPc, selInstr} = headEntry;
        end
    end

    assign fq.imem_req_o    = issue;
    assign fq.imem_addr_o   = fetchPc;
    assign fq.out_valid_o   = selVld && !fq.redirect_i && !reset;
    assign fq.out_pc_o      = selPc;
    assign fq.out_instr_o   = selInstr;
    assign fq.out_pcplus4_o = selVld ? selPc + ADDR_W'(PC_STEP) : '0;
    assign fq.count_o       = count;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && bufFull));

endmodule

// File: tb/tb_xgriscv_fetch_queue.sv
// Directed bench: DEPTH=4 instance at PC 0 and DEPTH=2 instance starting at 0xFFFF_FFF8, behind a 1-cycle IMEM model.
module tb_xgriscv_fetch_queue;

    logic clk;
    logic rst;
    logic rstW;
    int   nVec = 0;
    int   nErr = 0;

`ifdef XGRISCV_FQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    xgriscv_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(3)) fq ();
    xgriscv_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(2)) fqW ();

    xgriscv_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (rst),
        .fq    (fq.master)
    );

    xgriscv_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dutW (
        .clk   (clk),
        .reset (rstW),
        .fq    (fqW.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // IMEM models: data word is ~address, returned one cycle after the request.
    initial begin
        logic r;
        logic [31:0] a;
        r = 1'b0; a = '0;
        fq.imem_rvalid_i = 1'b0; fq.imem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            fq.imem_rvalid_i = r; fq.imem_rdata_i = ~a;
            #2;
            r = fq.imem_req_o; a = fq.imem_addr_o;
        end
    end

    initial begin
        logic r;
        logic [31:0] a;
        r = 1'b0; a = '0;
        fqW.imem_rvalid_i = 1'b0; fqW.imem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            fqW.imem_rvalid_i = r; fqW.imem_rdata_i = ~a;
            #2;
            r = fqW.imem_req_o; a = fqW.imem_addr_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    // Leaves the caller at the start of the first cycle after reset release.
    task automatic start_fq(input logic rdy);
        rst = 1'b1; fq.redirect_i = 1'b0; fq.out_ready_i = rdy;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc(); #1;
        nVec++; if (fq.imem_req_o !== 1'b0) begin nErr++; $display("FAIL reset_req: got %b want 0", fq.imem_req_o); end
        nVec++; if (fq.out_valid_o !== 1'b0) begin nErr++; $display("FAIL reset_valid: got %b want 0", fq.out_valid_o); end
        nVec++; if (fq.count_o !== 3'd0) begin nErr++; $display("FAIL reset_count: got %0d want 0", fq.count_o); end
        nVec++; if (fq.imem_addr_o !== 32'h0) begin nErr++; $display("FAIL reset_addr: got %h want 0", fq.imem_addr_o); end
        nVec++; if (fq.out_pc_o !== 32'h0 || fq.out_pcplus4_o !== 32'h0 || fq.out_instr_o !== 32'h0) begin
            nErr++; $display("FAIL reset_data: got pc %h pc4 %h instr %h want all 0", fq.out_pc_o, fq.out_pcplus4_o, fq.out_instr_o);
        end
        // Build up three entries, then reset asynchronously mid-cycle.
        start_fq(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
        end
        #1;
        nVec++; if (fq.count_o !== 3'd3) begin nErr++; $display("FAIL pre_reset_count: got %0d want 3", fq.count_o); end
        #1; rst = 1'b1; #1;
        nVec++; if (fq.out_valid_o !== 1'b0) begin nErr++; $display("FAIL async_reset_valid: got %b want 0", fq.out_valid_o); end
        nVec++; if (fq.count_o !== 3'd0) begin nErr++; $display("FAIL async_reset_count: got %0d want 0", fq.count_o); end
        nVec++; if (fq.imem_addr_o !== 32'h0) begin nErr++; $display("FAIL async_reset_addr: got %h want 0", fq.imem_addr_o); end
        nVec++; if (fq.imem_req_o !== 1'b0) begin nErr++; $display("FAIL async_reset_req: got %b want 0", fq.imem_req_o); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        start_fq(1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc();
            #1;
            nVec++; if (fq.imem_req_o !== 1'b1 || fq.imem_addr_o !== 32'(4 * i)) begin
                nErr++; $display("FAIL stream_req[%0d]: got req %b addr %h want 1 %h", i, fq.imem_req_o, fq.imem_addr_o, 32'(4 * i));
            end
            if (i >= LAT) begin
                e = 32'(4 * (i - LAT));
                nVec++; if (fq.out_valid_o !== 1'b1 || fq.out_pc_o !== e || fq.out_pcplus4_o !== e + 32'd4 || fq.out_instr_o !== ~e) begin
                    nErr++; $display("FAIL stream_out[%0d]: got v %b pc %h pc4 %h instr %h want 1 %h %h %h",
                                     i, fq.out_valid_o, fq.out_pc_o, fq.out_pcplus4_o, fq.out_instr_o, e, e + 32'd4, ~e);
                end
            end else begin
                nVec++; if (fq.out_valid_o !== 1'b0) begin nErr++; $display("FAIL stream_lat[%0d]: got valid %b want 0", i, fq.out_valid_o); end
            end
        end
    endtask

    task automatic test_stall();
        int ec;
        start_fq(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            #1;
            ec = (i < 2) ? 0 : ((i - 1 > 4) ? 4 : i - 1);
            nVec++; if (fq.count_o !== 3'(ec)) begin nErr++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, fq.count_o, ec); end
            nVec++; if (fq.imem_req_o !== (i < 4)) begin nErr++; $display("FAIL stall_req[%0d]: got %b want %b", i, fq.imem_req_o, (i < 4)); end
            if (i >= LAT) begin
                nVec++; if (fq.out_valid_o !== 1'b1 || fq.out_pc_o !== 32'h0) begin
                    nErr++; $display("FAIL stall_head[%0d]: got v %b pc %h want 1 0", i, fq.out_valid_o, fq.out_pc_o);
                end
            end
        end
        for (int j = 0; j < 6; j++) begin
            cyc();
            fq.out_ready_i = 1'b1;
            #1;
            nVec++; if (fq.out_valid_o !== 1'b1 || fq.out_pc_o !== 32'(4 * j)) begin
                nErr++; $display("FAIL stall_drain[%0d]: got v %b pc %h want 1 %h", j, fq.out_valid_o, fq.out_pc_o, 32'(4 * j));
            end
        end
    endtask

    task automatic test_redirect();
        int got;
        start_fq(1'b0);
        for (int i = 1; i < 4; i++) cyc();
        cyc();
        fq.redirect_i = 1'b1; fq.redirect_pc_i = 32'h0000_0103;
        #1;
        nVec++; if (fq.count_o !== 3'd3 || fq.imem_rvalid_i !== 1'b1) begin
            nErr++; $display("FAIL redir_setup: got count %0d rvalid %b want 3 1", fq.count_o, fq.imem_rvalid_i);
        end
        nVec++; if (fq.out_valid_o !== 1'b0 || fq.imem_req_o !== 1'b0) begin
            nErr++; $display("FAIL redir_comb: got valid %b req %b want 0 0", fq.out_valid_o, fq.imem_req_o);
        end
        cyc();
        fq.redirect_i = 1'b0; fq.out_ready_i = 1'b1;
        #1;
        nVec++; if (fq.imem_addr_o !== 32'h100 || fq.imem_req_o !== 1'b1) begin
            nErr++; $display("FAIL redir_target: got addr %h req %b want 00000100 1", fq.imem_addr_o, fq.imem_req_o);
        end
        nVec++; if (fq.count_o !== 3'd0 || fq.out_valid_o !== 1'b0) begin
            nErr++; $display("FAIL redir_flush: got count %0d valid %b want 0 0", fq.count_o, fq.out_valid_o);
        end
        got = 0;
        for (int k = 0; k < 8 && got < 3; k++) begin
            cyc(); #1;
            if (fq.out_valid_o === 1'b1) begin
                nVec++; if (fq.out_pc_o !== 32'(32'h100 + 4 * got)) begin
                    nErr++; $display("FAIL redir_stream[%0d]: got pc %h want %h", got, fq.out_pc_o, 32'(32'h100 + 4 * got));
                end
                got++;
            end
        end
        nVec++; if (got != 3) begin nErr++; $display("FAIL redir_timeout: got %0d entries want 3", got); end
    endtask

    task automatic test_back_to_back();
        int got;
        cyc();
        fq.redirect_i = 1'b1; fq.redirect_pc_i = 32'h0000_0200;
        #1;
        nVec++; if (fq.out_valid_o !== 1'b0 || fq.imem_req_o !== 1'b0) begin
            nErr++; $display("FAIL b2b_first: got valid %b req %b want 0 0", fq.out_valid_o, fq.imem_req_o);
        end
        cyc();
        fq.redirect_pc_i = 32'h0000_0301;
        #1;
        nVec++; if (fq.imem_addr_o !== 32'h200 || fq.out_valid_o !== 1'b0) begin
            nErr++; $display("FAIL b2b_second: got addr %h valid %b want 00000200 0", fq.imem_addr_o, fq.out_valid_o);
        end
        cyc();
        fq.redirect_i = 1'b0;
        #1;
        nVec++; if (fq.imem_addr_o !== 32'h300 || fq.imem_req_o !== 1'b1) begin
            nErr++; $display("FAIL b2b_target: got addr %h req %b want 00000300 1", fq.imem_addr_o, fq.imem_req_o);
        end
        got = 0;
        for (int k = 0; k < 6 && got < 1; k++) begin
            cyc(); #1;
            if (fq.out_valid_o === 1'b1) begin
                nVec++; if (fq.out_pc_o !== 32'h300) begin nErr++; $display("FAIL b2b_first_pc: got %h want 00000300", fq.out_pc_o); end
                got++;
            end
        end
        nVec++; if (got != 1) begin nErr++; $display("FAIL b2b_timeout: got %0d entries want 1", got); end
    endtask

    task automatic test_wrap();
        int got;
        logic [31:0] e;
        rstW = 1'b1; fqW.redirect_i = 1'b0; fqW.redirect_pc_i = '0; fqW.out_ready_i = 1'b1;
        cyc(); cyc();
        rstW = 1'b0;
        #1;
        nVec++; if (fqW.imem_addr_o !== 32'hFFFF_FFF8 || fqW.count_o !== 2'd0 || fqW.out_valid_o !== 1'b0) begin
            nErr++; $display("FAIL wrap_start: got addr %h count %0d valid %b want fffffff8 0 0", fqW.imem_addr_o, fqW.count_o, fqW.out_valid_o);
        end
        got = 0;
        for (int c = 0; c < 16 && got < 4; c++) begin
            if (c > 0) begin cyc(); #1; end
            if (fqW.out_valid_o === 1'b1) begin
                e = 32'hFFFF_FFF8 + 32'(4 * got);
                nVec++; if (fqW.out_pc_o !== e || fqW.out_pcplus4_o !== e + 32'd4 || fqW.out_instr_o !== ~e) begin
                    nErr++; $display("FAIL wrap_pc[%0d]: got pc %h pc4 %h instr %h want %h %h %h",
                                     got, fqW.out_pc_o, fqW.out_pcplus4_o, fqW.out_instr_o, e, e + 32'd4, ~e);
                end
`ifdef XGRISCV_FQ_BYPASS_EN
                nVec++; if (c != got + 1) begin nErr++; $display("FAIL bypass_rate[%0d]: got cycle %0d want %0d", got, c, got + 1); end
`endif
                got++;
            end
        end
        nVec++; if (got != 4) begin nErr++; $display("FAIL wrap_timeout: got %0d entries want 4", got); end
    endtask

    initial begin
        rst = 1'b1; rstW = 1'b1;
        fq.redirect_i = 1'b0; fq.redirect_pc_i = '0; fq.out_ready_i = 1'b1;
        fqW.redirect_i = 1'b0; fqW.redirect_pc_i = '0; fqW.out_ready_i = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
